// File: rtl/generic_fifo_serializer.sv
// Pops wide words from a FIFO and emits them as RATIO narrow beats, LSB beat first.
// Optional last_o beat marker is enabled with `define SERIALIZER_LAST_EN.
module generic_fifo_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  data_i,
    input  logic                 valid_i,
    output logic                 grant_o,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 grant_i,
    output logic                 busy_o
`ifdef SERIALIZER_LAST_EN
    ,
    output logic                 last_o
`endif
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_param_err
        $error("generic_fifo_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IN_WIDTH-1:0]  wreg;
    logic                 in_send;
    logic                 at_last;

    assign in_send = (state == SEND);
    assign at_last = (cnt == CNT_LAST);

    // Any state other than SEND behaves as IDLE, so an illegal encoding still accepts a pop.
    assign grant_o = !in_send || (grant_i && at_last);
    assign valid_o = in_send;
    assign busy_o  = in_send;
    assign data_o  = wreg[int'(cnt) * OUT_WIDTH +: OUT_WIDTH];

`ifdef SERIALIZER_LAST_EN
    assign last_o = in_send && at_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            wreg  <= '0;
        end else begin
            case (state)
                SEND: begin
                    if (grant_i) begin
                        if (!at_last) begin
                            cnt <= cnt + 1'b1;
                        end else if (valid_i) begin
                            // Final beat accepted and next word ready: reload with no bubble.
                            wreg <= data_i;
                            cnt  <= '0;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                    if (valid_i) begin
                        wreg  <= data_i;
                        state <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
